// File: rtl/dla_tile_sequencer_pkg.sv
// Shared types and constants for the DLA tile sequencer.
package dla_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_WAIT_DONE,
    S_NEXT,
    S_ERR
  } seq_state_e;

  localparam logic [1:0] WSEL_MAPPING = 2'd0;
  localparam logic [1:0] WSEL_SHAPE1  = 2'd1;
  localparam logic [1:0] WSEL_SHAPE2  = 2'd2;
  localparam logic [1:0] WSEL_OPCFG   = 2'd3;

  localparam int DESC_WORDS = 4;

endpackage

// File: rtl/dla_tile_sequencer_if.sv
// Control-register write port towards Top plus its completion flag.
// Sequencer is master (drives writes, samples dla_done); Top is slave.
interface dla_tile_sequencer_if;
  logic        ctrl_reg_w_en;
  logic [1:0]  ctrl_reg_wsel;
  logic [31:0] ctrl_reg_wdata;
  logic        dla_done;

  modport master (
    output ctrl_reg_w_en,
    output ctrl_reg_wsel,
    output ctrl_reg_wdata,
    input  dla_done
  );

  modport slave (
    input  ctrl_reg_w_en,
    input  ctrl_reg_wsel,
    input  ctrl_reg_wdata,
    output dla_done
  );
endinterface

// File: rtl/seq_desc_regfile.sv
// Descriptor store: one write port, one combinational read port, async clear.
// Write lands on the next edge; out-of-range writes are dropped, no backpressure.
module seq_desc_regfile #(
  parameter int DEPTH = 80,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/dla_tile_sequencer.sv
// Replays stored tile descriptors into Top's control registers, one tile per dla_done.
// Start to first write is one cycle; all outputs registered; host writes/start ignored while busy.
module dla_tile_sequencer
  import dla_seq_pkg::*;
#(
  parameter int  MAX_TILE = 20,
  parameter int  TIMEOUT  = 500000,
  parameter int  GAP      = 1,
  localparam int AW       = $clog2(MAX_TILE * DESC_WORDS),
  localparam int NW       = $clog2(MAX_TILE + 1),
  localparam int TW       = $clog2(MAX_TILE),
  localparam int CW       = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_waddr,
  input  logic [31:0]           host_wdata,
  input  logic                  start,
  input  logic [NW-1:0]         num_tiles,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic [TW-1:0]         cur_tile,
  dla_tile_sequencer_if.master  ctrl
);

  localparam logic [2:0]    GAP_LAST  = 3'(GAP - 1);
  localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TOUT_SAT  = CW'(TIMEOUT);

  seq_state_e    state, state_nxt;
  logic [1:0]    k, k_nxt;
  logic [TW-1:0] tile_nxt;
  logic [NW-1:0] n_tiles, n_nxt;
  logic [2:0]    gcnt, gcnt_nxt;
  logic [CW-1:0] tcnt, tcnt_nxt;
  logic          armed, armed_nxt;
  logic          busy_nxt, done_nxt, terr_nxt, gap_exit, w_en_nxt;
  logic [AW-1:0] raddr;
  logic [31:0]   rd_dat;

  seq_desc_regfile #(
    .DEPTH (MAX_TILE * DESC_WORDS),
    .AW    (AW)
  ) u_desc (
    .clk   (clk),
    .rst   (rst),
    .we    (host_we && !busy),
    .waddr (host_waddr),
    .wdata (host_wdata),
    .raddr (raddr),
    .rdata (rd_dat)
  );

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    tile_nxt  = cur_tile;
    n_nxt     = n_tiles;
    gcnt_nxt  = gcnt;
    tcnt_nxt  = tcnt;
    armed_nxt = armed;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    terr_nxt  = timeout_err;
    gap_exit  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          n_nxt    = (int'(num_tiles) > MAX_TILE) ? NW'(MAX_TILE) : num_tiles;
          tile_nxt = '0;
          k_nxt    = WSEL_MAPPING;
          terr_nxt = 1'b0;
          if (num_tiles == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = S_WRITE;
            busy_nxt  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (GAP == 0) begin
          gap_exit = 1'b1;
        end else begin
          state_nxt = S_GAP;
          gcnt_nxt  = '0;
        end
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) gap_exit = 1'b1;
        else                  gcnt_nxt = gcnt + 3'd1;
      end
      S_WAIT_DONE: begin
        tcnt_nxt = (tcnt == TOUT_SAT) ? tcnt : tcnt + CW'(1);
        // armed only after a low cycle, so a done still high from the last tile is ignored
        if (ctrl.dla_done && armed) begin
          state_nxt = S_NEXT;
        end else begin
          if (!ctrl.dla_done) armed_nxt = 1'b1;
          if (tcnt >= TOUT_LAST) state_nxt = S_ERR;
        end
      end
      S_NEXT: begin
        if (int'(cur_tile) + 1 == int'(n_tiles)) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          tile_nxt  = cur_tile + TW'(1);
          k_nxt     = WSEL_MAPPING;
          state_nxt = S_WRITE;
        end
      end
      S_ERR: begin
        terr_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (gap_exit) begin
      if (k != WSEL_OPCFG) begin
        k_nxt     = k + 2'd1;
        state_nxt = S_WRITE;
      end else begin
        armed_nxt = 1'b0;
        tcnt_nxt  = '0;
        state_nxt = S_WAIT_DONE;
      end
    end

    w_en_nxt = (state_nxt == S_WRITE);
    raddr    = AW'(int'(tile_nxt) * DESC_WORDS + int'(k_nxt));
  end

  // Output registers load from next-state values so a write appears the cycle its state is entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      k                   <= '0;
      cur_tile            <= '0;
      n_tiles             <= '0;
      gcnt                <= '0;
      tcnt                <= '0;
      armed               <= 1'b0;
      busy                <= 1'b0;
      seq_done            <= 1'b0;
      timeout_err         <= 1'b0;
      ctrl.ctrl_reg_w_en  <= 1'b0;
      ctrl.ctrl_reg_wsel  <= '0;
      ctrl.ctrl_reg_wdata <= '0;
    end else begin
      state              <= state_nxt;
      k                  <= k_nxt;
      cur_tile           <= tile_nxt;
      n_tiles            <= n_nxt;
      gcnt               <= gcnt_nxt;
      tcnt               <= tcnt_nxt;
      armed              <= armed_nxt;
      busy               <= busy_nxt;
      seq_done           <= done_nxt;
      timeout_err        <= terr_nxt;
      ctrl.ctrl_reg_w_en <= w_en_nxt;
      if (w_en_nxt) begin
        ctrl.ctrl_reg_wsel  <= k_nxt;
        ctrl.ctrl_reg_wdata <= rd_dat;
      end
    end
  end

endmodule

// File: tb/tb_dla_tile_sequencer.sv
// Directed bench for dla_tile_sequencer with a simple Top done model.
module tb_dla_tile_sequencer;
  import dla_seq_pkg::*;

  localparam int MAX_TILE = 20;
  localparam int TIMEOUT  = 100;
  localparam int GAP      = 1;
  localparam int AW       = $clog2(MAX_TILE * 4);
  localparam int NW       = $clog2(MAX_TILE + 1);
  localparam int TW       = $clog2(MAX_TILE);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_waddr = '0;
  logic [31:0]   host_wdata = '0;
  logic          start = 1'b0;
  logic [NW-1:0] num_tiles = '0;
  logic          busy, seq_done, timeout_err;
  logic [TW-1:0] cur_tile;

  logic auto_mode  = 1'b0;
  logic man_done   = 1'b0;
  logic model_done = 1'b0;
  int   mcnt       = 0;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_desc [MAX_TILE*4];
  logic [1:0]  log_sel [1024];
  logic [31:0] log_dat [1024];
  int          wr_n = 0;
  int          sd_count = 0;

  dla_tile_sequencer_if bus();
  assign bus.dla_done = auto_mode ? model_done : man_done;

  dla_tile_sequencer #(
    .MAX_TILE (MAX_TILE),
    .TIMEOUT  (TIMEOUT),
    .GAP      (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_we     (host_we),
    .host_waddr  (host_waddr),
    .host_wdata  (host_wdata),
    .start       (start),
    .num_tiles   (num_tiles),
    .busy        (busy),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .cur_tile    (cur_tile),
    .ctrl        (bus)
  );

  always #5 clk = ~clk;

  // Top model: done drops on op_config and rises 50 cycles later
  always @(posedge clk) begin
    if (bus.ctrl_reg_w_en && bus.ctrl_reg_wsel == 2'd3) begin
      model_done <= 1'b0;
      mcnt       <= 50;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      model_done <= 1'b1;
      mcnt       <= 0;
    end
  end

  always @(negedge clk) begin
    if (bus.ctrl_reg_w_en && wr_n < 1024) begin
      log_sel[wr_n] <= bus.ctrl_reg_wsel;
      log_dat[wr_n] <= bus.ctrl_reg_wdata;
      wr_n          <= wr_n + 1;
    end
    if (seq_done) sd_count <= sd_count + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int addr, input logic [31:0] data, input bit model);
    host_we    = 1'b1;
    host_waddr = AW'(addr);
    host_wdata = data;
    tick();
    host_we = 1'b0;
    if (model) exp_desc[addr] = data;
  endtask

  task automatic load_tile(input int t, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    host_write(t*4 + 0, w0, 1'b1);
    host_write(t*4 + 1, w1, 1'b1);
    host_write(t*4 + 2, w2, 1'b1);
    host_write(t*4 + 3, w3, 1'b1);
  endtask

  task automatic pulse_start(input int n);
    num_tiles = NW'(n);
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_seq_done(input int sd_base, input int limit);
    int n;
    n = 0;
    while (sd_count == sd_base && n < limit) begin
      tick();
      n++;
    end
    chk("wait_seq_done", 32'(sd_count != sd_base), 32'd1);
  endtask

  task automatic check_run(input int base, input int nt);
    chk("num_writes", wr_n - base, nt * 4);
    for (int i = 0; i < nt * 4 && base + i < wr_n; i++) begin
      chk($sformatf("wsel[%0d]", i), 32'(log_sel[base + i]), i % 4);
      chk($sformatf("wdata[%0d]", i), log_dat[base + i], exp_desc[i]);
    end
  endtask

  initial begin
    int wb, sb;
    for (int i = 0; i < MAX_TILE * 4; i++) exp_desc[i] = '0;

    // reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_seq_done", 32'(seq_done), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_cur_tile", 32'(cur_tile), 0);
    chk("rst_w_en", 32'(bus.ctrl_reg_w_en), 0);
    chk("rst_wsel", 32'(bus.ctrl_reg_wsel), 0);
    chk("rst_wdata", bus.ctrl_reg_wdata, 0);
    rst = 1'b1;
    tick();

    load_tile(0, 32'h000484ca, 32'h01f01808, 32'h00002222, 32'h00000001);
    load_tile(1, 32'h11110000, 32'h11110001, 32'h11110002, 32'h11110003);

    // basic run, two tiles
    auto_mode = 1'b1;
    wb = wr_n;
    sb = sd_count;
    pulse_start(2);
    chk("first_w_en", 32'(bus.ctrl_reg_w_en), 1);
    chk("first_wsel", 32'(bus.ctrl_reg_wsel), 0);
    chk("first_wdata", bus.ctrl_reg_wdata, 32'h000484ca);
    chk("first_busy", 32'(busy), 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("w_en_pattern[%0d]", i), 32'(bus.ctrl_reg_w_en), 32'((i % 2) == 0));
    end
    wait_seq_done(sb, 400);
    tick();
    chk("basic_seq_done_pulse", 32'(seq_done), 0);
    chk("basic_busy_after", 32'(busy), 0);
    chk("basic_seq_done_count", sd_count - sb, 1);
    check_run(wb, 2);

    // stale done held into WAIT_DONE
    auto_mode = 1'b0;
    man_done  = 1'b1;
    wb = wr_n;
    sb = sd_count;
    pulse_start(1);
    repeat (20) tick();
    chk("stale_busy", 32'(busy), 1);
    chk("stale_no_done", sd_count - sb, 0);
    man_done = 1'b0;
    tick();
    man_done = 1'b1;
    tick();
    chk("stale_next_seq_done", 32'(seq_done), 0);
    chk("stale_next_busy", 32'(busy), 1);
    tick();
    chk("stale_seq_done", 32'(seq_done), 1);
    chk("stale_busy_after", 32'(busy), 0);
    check_run(wb, 1);

    // timeout with done stuck low
    man_done = 1'b0;
    sb = sd_count;
    pulse_start(1);
    repeat (107) tick();
    chk("tout_busy_108", 32'(busy), 1);
    tick();
    chk("tout_busy_err", 32'(busy), 1);
    chk("tout_err_early", 32'(timeout_err), 0);
    tick();
    chk("tout_busy_idle", 32'(busy), 0);
    chk("tout_err_set", 32'(timeout_err), 1);
    tick();
    chk("tout_err_sticky", 32'(timeout_err), 1);
    chk("tout_no_seq_done", sd_count - sb, 0);

    // zero tiles, also clears timeout_err
    wb = wr_n;
    pulse_start(0);
    chk("zero_seq_done", 32'(seq_done), 1);
    chk("zero_err_cleared", 32'(timeout_err), 0);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_w_en", 32'(bus.ctrl_reg_w_en), 0);
    tick();
    chk("zero_seq_done_pulse", 32'(seq_done), 0);
    chk("zero_no_writes", wr_n - wb, 0);

    // clamp 25 -> 20 tiles
    auto_mode = 1'b1;
    wb = wr_n;
    sb = sd_count;
    pulse_start(25);
    wait_seq_done(sb, 3000);
    tick();
    chk("clamp_cur_tile", 32'(cur_tile), 19);
    chk("clamp_busy", 32'(busy), 0);
    chk("clamp_seq_done_count", sd_count - sb, 1);
    check_run(wb, 20);

    // start and host writes ignored while busy
    wb = wr_n;
    sb = sd_count;
    pulse_start(2);
    tick();
    for (int i = 0; i < 4; i++) host_write(4 + i, 32'hdead0000 + 32'(i), 1'b0);
    num_tiles = NW'(1);
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_seq_done(sb, 400);
    tick();
    chk("busy_ign_seq_done_count", sd_count - sb, 1);
    chk("busy_ign_cur_tile", 32'(cur_tile), 1);
    check_run(wb, 2);

    // reset during the gap after tile0 wsel=2
    pulse_start(2);
    repeat (5) tick();
    chk("midrst_pos_wsel", 32'(bus.ctrl_reg_wsel), 2);
    chk("midrst_pos_w_en", 32'(bus.ctrl_reg_w_en), 0);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_seq_done", 32'(seq_done), 0);
    chk("midrst_timeout_err", 32'(timeout_err), 0);
    chk("midrst_cur_tile", 32'(cur_tile), 0);
    chk("midrst_w_en", 32'(bus.ctrl_reg_w_en), 0);
    chk("midrst_wsel", 32'(bus.ctrl_reg_wsel), 0);
    chk("midrst_wdata", bus.ctrl_reg_wdata, 0);
    for (int i = 0; i < MAX_TILE * 4; i++) exp_desc[i] = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("postrst_busy", 32'(busy), 0);
    load_tile(0, 32'hc0de0000, 32'hc0de0001, 32'hc0de0002, 32'hc0de0003);
    wb = wr_n;
    sb = sd_count;
    pulse_start(2);
    wait_seq_done(sb, 400);
    tick();
    chk("postrst_seq_done_count", sd_count - sb, 1);
    check_run(wb, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
